regfile_writeback: RTL and testbench

//  Write-side controller for the 32x32 RISC-V register file. It merges single-cycle ALU results
//  and out-of-order-in-time (but in-order) memory load responses into the single rf write port.
//  It also holds a busy scoreboard so decode stalls on pending-load hazards.

---
 rtl/regfile_writeback.sv | 212 +++++++++++++++++++++
 tb/tb_regfile_writeback.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Write-side controller for the 32x32 register file: merges ALU results and in-order load responses
// into one write port and keeps a busy scoreboard. Optional forwarding: define REGFILE_WB_BYPASS_EN.
module regfile_writeback #(
   parameter int LD_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        ld_issue_valid,
   input  logic [4:0]  ld_issue_rd,
   input  logic [2:0]  ld_issue_funct3,
   input  logic [1:0]  ld_issue_off,
   output logic        ld_issue_ready,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        mem_rsp_ready,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic [4:0]  dec_rd,
   output logic        dec_stall,
`ifdef REGFILE_WB_BYPASS_EN
   output logic        fwd_rs1_hit,
   output logic        fwd_rs2_hit,
   output logic [31:0] fwd_rs1_data,
   output logic [31:0] fwd_rs2_data,
`endif
   output logic [4:0]  rf_addr_rd,
   output logic [31:0] rf_data_rd,
   output logic        rf_write_enable
);

   // LD_DEPTH must be a power of two so the pointers wrap naturally.
   localparam int              PTR_W   = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [PTR_W:0]   CNT_ONE = 1;
   localparam logic [PTR_W:0]   CNT_MAX = LD_DEPTH[PTR_W:0];

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } funct3_e;

   typedef struct packed {
      logic [4:0] rd;
      logic [2:0] funct3;
      logic [1:0] off;
   } ld_entry_t;

   // Pending-load FIFO
   ld_entry_t        fifo_q [LD_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;

   // Load captured when it collides with an ALU write
   logic        hold_valid_q, hold_valid_d;
   logic [4:0]  hold_rd_q, hold_rd_d;
   logic [31:0] hold_data_q, hold_data_d;

   logic [31:0] busy_q, busy_d;
   logic [31:0] busy_set, busy_clr, busy_eff;

   logic        fifo_empty, fifo_full;
   logic        issue_fire, rsp_accept, pop;
   ld_entry_t   head, issue_entry;
   logic [31:0] ld_fmt;

   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        ld_write;

   function automatic logic [31:0] format_load(input logic [31:0] raw,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = raw[{off, 3'b000} +: 8];
      h = off[1] ? raw[31:16] : raw[15:0];
      case (f3)
         F3_LB:   r = {{24{b[7]}}, b};
         F3_LH:   r = {{16{h[15]}}, h};
         F3_LBU:  r = {24'd0, b};
         F3_LHU:  r = {16'd0, h};
         F3_LW:   r = raw;
         default: r = raw;
      endcase
      return r;
   endfunction

   assign fifo_empty     = (count_q == '0);
   assign fifo_full      = (count_q == CNT_MAX);
   assign ld_issue_ready = !fifo_full;
   assign mem_rsp_ready  = !hold_valid_q;

   assign issue_fire  = ld_issue_valid && ld_issue_ready;
   // Responses with nothing pending are still accepted, then simply dropped.
   assign rsp_accept  = mem_rsp_valid && mem_rsp_ready;
   assign pop         = rsp_accept && !fifo_empty;

   assign head        = fifo_q[rd_ptr_q];
   assign issue_entry = '{rd: ld_issue_rd, funct3: ld_issue_funct3, off: ld_issue_off};
   assign ld_fmt      = format_load(mem_rsp_data, head.funct3, head.off);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (issue_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)        rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({issue_fire, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Write arbitration: ALU first, then a held load, then a fresh response.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned
      // (which would infer a latch).
      wr_en        = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      ld_write     = 1'b0;
      hold_valid_d = hold_valid_q;
      hold_rd_d    = hold_rd_q;
      hold_data_d  = hold_data_q;
      if (alu_valid) begin
         wr_en   = (alu_rd != 5'd0);
         wr_addr = alu_rd;
         wr_data = alu_data;
         if (pop) begin
            hold_valid_d = 1'b1;
            hold_rd_d    = head.rd;
            hold_data_d  = ld_fmt;
         end
      end else if (hold_valid_q) begin
         wr_en        = (hold_rd_q != 5'd0);
         wr_addr      = hold_rd_q;
         wr_data      = hold_data_q;
         ld_write     = 1'b1;
         hold_valid_d = 1'b0;
      end else if (pop) begin
         wr_en    = (head.rd != 5'd0);
         wr_addr  = head.rd;
         wr_data  = ld_fmt;
         ld_write = 1'b1;
      end
   end

   assign rf_write_enable = wr_en && !reset;
   assign rf_addr_rd      = wr_addr;
   assign rf_data_rd      = wr_data;

   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (issue_fire && ld_issue_rd != 5'd0) busy_set[ld_issue_rd] = 1'b1;
      if (ld_write)                          busy_clr[wr_addr]     = 1'b1;
      // Set after clear, so an issue to the register being retired keeps it busy.
      busy_d = ((busy_q & ~busy_clr) | busy_set) & 32'hFFFF_FFFE;
   end

`ifdef REGFILE_WB_BYPASS_EN
   assign busy_eff     = busy_q & ~busy_clr;
   assign fwd_rs1_hit  = rf_write_enable && (dec_rs1 == rf_addr_rd);
   assign fwd_rs2_hit  = rf_write_enable && (dec_rs2 == rf_addr_rd);
   assign fwd_rs1_data = rf_data_rd;
   assign fwd_rs2_data = rf_data_rd;
`else
   assign busy_eff = busy_q;
`endif

   assign dec_stall = busy_eff[dec_rs1] | busy_eff[dec_rs2] | busy_eff[dec_rd];

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // the pre-edge values regardless of statement order.
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         hold_valid_q <= 1'b0;
         busy_q       <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         hold_valid_q <= hold_valid_d;
         busy_q       <= busy_d;
      end
   end

   always_ff @(posedge clock) begin
      hold_rd_q   <= hold_rd_d;
      hold_data_q <= hold_data_d;
   end

   // NOTE: FIFO storage is deliberately not reset; entries are only read when the
   // reset-cleared count says they are valid.
   always_ff @(posedge clock) begin
      if (issue_fire) fifo_q[wr_ptr_q] <= issue_entry;
   end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback; forwarding checks apply when
// REGFILE_WB_BYPASS_EN is defined.
module tb_regfile_writeback;

   logic        clock;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_issue_valid;
   logic [4:0]  ld_issue_rd;
   logic [2:0]  ld_issue_funct3;
   logic [1:0]  ld_issue_off;
   logic        ld_issue_ready;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        mem_rsp_ready;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic        dec_stall;
`ifdef REGFILE_WB_BYPASS_EN
   logic        fwd_rs1_hit, fwd_rs2_hit;
   logic [31:0] fwd_rs1_data, fwd_rs2_data;
`endif
   logic [4:0]  rf_addr_rd;
   logic [31:0] rf_data_rd;
   logic        rf_write_enable;

   int vectors;
   int miscompares;

   regfile_writeback #(.LD_DEPTH(2)) dut (
      .clock           (clock),
      .reset           (reset),
      .alu_valid       (alu_valid),
      .alu_rd          (alu_rd),
      .alu_data        (alu_data),
      .ld_issue_valid  (ld_issue_valid),
      .ld_issue_rd     (ld_issue_rd),
      .ld_issue_funct3 (ld_issue_funct3),
      .ld_issue_off    (ld_issue_off),
      .ld_issue_ready  (ld_issue_ready),
      .mem_rsp_valid   (mem_rsp_valid),
      .mem_rsp_data    (mem_rsp_data),
      .mem_rsp_ready   (mem_rsp_ready),
      .dec_rs1         (dec_rs1),
      .dec_rs2         (dec_rs2),
      .dec_rd          (dec_rd),
      .dec_stall       (dec_stall),
`ifdef REGFILE_WB_BYPASS_EN
      .fwd_rs1_hit     (fwd_rs1_hit),
      .fwd_rs2_hit     (fwd_rs2_hit),
      .fwd_rs1_data    (fwd_rs1_data),
      .fwd_rs2_data    (fwd_rs2_data),
`endif
      .rf_addr_rd      (rf_addr_rd),
      .rf_data_rd      (rf_data_rd),
      .rf_write_enable (rf_write_enable)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      alu_valid       = 1'b0;
      alu_rd          = 5'd0;
      alu_data        = 32'd0;
      ld_issue_valid  = 1'b0;
      ld_issue_rd     = 5'd0;
      ld_issue_funct3 = 3'd0;
      ld_issue_off    = 2'd0;
      mem_rsp_valid   = 1'b0;
      mem_rsp_data    = 32'd0;
      dec_rs1         = 5'd0;
      dec_rs2         = 5'd0;
      dec_rd          = 5'd0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
      ld_issue_valid  = 1'b1;
      ld_issue_rd     = rd;
      ld_issue_funct3 = f3;
      ld_issue_off    = off;
   endtask

   task automatic rsp(input logic [31:0] data);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = data;
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_write(input string tag, input logic [4:0] addr, input logic [31:0] data);
      chk({tag, "_we"}, rf_write_enable, 1);
      chk({tag, "_addr"}, rf_addr_rd, addr);
      chk({tag, "_data"}, rf_data_rd, data);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      idle();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      dec_rs1 = 5'd7; dec_rs2 = 5'd9; dec_rd = 5'd4;
      #1;
      chk("rst_we", rf_write_enable, 0);
      chk("rst_stall", dec_stall, 0);
      chk("rst_ld_ready", ld_issue_ready, 1);
      chk("rst_rsp_ready", mem_rsp_ready, 1);
      reset = 1'b0;
      idle();
      tick();

      // ALU write, then ALU write to x0
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
      #1; chk_write("alu", 5'd5, 32'h0000_1234);
      tick(); idle();
      dec_rs1 = 5'd5;
      #1; chk("alu_no_busy", dec_stall, 0); chk("idle_we", rf_write_enable, 0);
      tick(); idle();
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_FFFF;
      #1; chk("alu_x0_we", rf_write_enable, 0);
      tick(); idle();

      // LB x7, off 3, with a dependent decode
      issue(5'd7, 3'b000, 2'd3); dec_rs1 = 5'd7;
      #1; chk("lb_issue_ready", ld_issue_ready, 1); chk("lb_issue_stall", dec_stall, 0);
      chk("lb_issue_we", rf_write_enable, 0);
      tick(); idle();
      dec_rs1 = 5'd7;
      #1; chk("lb_rs1_stall", dec_stall, 1);
      tick(); idle();
      dec_rd = 5'd7;
      #1; chk("lb_rd_stall", dec_stall, 1);
      tick(); idle();
      rsp(32'h80FF_FF00); dec_rs1 = 5'd7;
      #1; chk_write("lb", 5'd7, 32'hFFFF_FF80); chk("lb_rsp_ready", mem_rsp_ready, 1);
`ifdef REGFILE_WB_BYPASS_EN
      chk("lb_wr_stall", dec_stall, 0);
      chk("lb_fwd_hit", fwd_rs1_hit, 1);
      chk("lb_fwd_data", fwd_rs1_data, 32'hFFFF_FF80);
`else
      chk("lb_wr_stall", dec_stall, 1);
`endif
      tick(); idle();
      dec_rs1 = 5'd7;
      #1; chk("lb_after_stall", dec_stall, 0); chk("lb_after_we", rf_write_enable, 0);
      tick(); idle();

      // Fill FIFO with LH x10 and LHU x11, try an extra issue
      issue(5'd10, 3'b001, 2'd2);
      tick(); idle();
      issue(5'd11, 3'b101, 2'd0);
      #1; chk("fill_ready", ld_issue_ready, 1);
      tick(); idle();
      issue(5'd12, 3'b100, 2'd1); dec_rs1 = 5'd10; dec_rs2 = 5'd11;
      #1; chk("full_ready", ld_issue_ready, 0); chk("full_stall", dec_stall, 1);
      tick(); idle();
      dec_rs1 = 5'd12; rsp(32'h8001_7FFF);
      #1; chk("full_ignored_stall", dec_stall, 0);
      chk_write("lh", 5'd10, 32'hFFFF_8001); chk("pop_ready", ld_issue_ready, 0);
      tick(); idle();
      dec_rs1 = 5'd10; rsp(32'h0000_9ABC);
      #1; chk("after_pop_ready", ld_issue_ready, 1); chk("lh_clear_stall", dec_stall, 0);
      chk_write("lhu", 5'd11, 32'h0000_9ABC);
      tick(); idle();
      issue(5'd12, 3'b100, 2'd1);
      tick(); idle();
      rsp(32'h1234_F678);
      #1; chk_write("lbu", 5'd12, 32'h0000_00F6);
      tick(); idle();

      // ALU/response collision: LW x4 held behind ALU writes
      issue(5'd4, 3'b010, 2'd0);
      tick(); idle();
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA_0003; rsp(32'hDEAD_BEEF);
      #1; chk_write("coll_alu", 5'd3, 32'hAAAA_0003); chk("coll_rsp_ready", mem_rsp_ready, 1);
      tick(); idle();
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0033; rsp(32'h5555_5555);
      dec_rs1 = 5'd4;
      #1; chk("hold_rsp_ready", mem_rsp_ready, 0); chk_write("hold_alu", 5'd3, 32'h0000_0033);
      chk("hold_stall", dec_stall, 1);
      tick(); idle();
      rsp(32'h5555_5555); dec_rs1 = 5'd4;
      #1; chk("drain_rsp_ready", mem_rsp_ready, 0); chk_write("drain", 5'd4, 32'hDEAD_BEEF);
`ifdef REGFILE_WB_BYPASS_EN
      chk("drain_stall", dec_stall, 0);
`else
      chk("drain_stall", dec_stall, 1);
`endif
      tick(); idle();
      dec_rs1 = 5'd4;
      #1; chk("drained_rsp_ready", mem_rsp_ready, 1); chk("drained_we", rf_write_enable, 0);
      chk("drained_stall", dec_stall, 0);
      tick(); idle();

      // Load to x0 still pops the FIFO
      issue(5'd0, 3'b010, 2'd0);
      #1; chk("x0_issue_stall", dec_stall, 0);
      tick(); idle();
      rsp(32'h0000_1111);
      #1; chk("x0_rsp_we", rf_write_enable, 0);
      tick(); idle();
      issue(5'd15, 3'b010, 2'd0);
      tick(); idle();
      dec_rs1 = 5'd15;
      #1; chk("x0_popped_ready", ld_issue_ready, 1); chk("x15_stall", dec_stall, 1);
      tick(); idle();

      // Reset with x15 pending, then an orphan response
      reset = 1'b1;
      tick();
      reset = 1'b0; idle();
      dec_rs1 = 5'd15; rsp(32'h0000_2222);
      #1; chk("mid_rst_stall", dec_stall, 0); chk("mid_rst_ready", ld_issue_ready, 1);
      chk("orphan_we", rf_write_enable, 0); chk("orphan_rsp_ready", mem_rsp_ready, 1);
      tick(); idle();
      issue(5'd16, 3'b010, 2'd0);
      tick(); idle();
      issue(5'd17, 3'b010, 2'd0);
      #1; chk("post_orphan_ready", ld_issue_ready, 1);
      tick(); idle();
      rsp(32'hCAFE_F00D);
      #1; chk("post_orphan_full", ld_issue_ready, 0); chk_write("lw16", 5'd16, 32'hCAFE_F00D);
      tick(); idle();
      rsp(32'h0BAD_C0DE);
      #1; chk_write("lw17", 5'd17, 32'h0BAD_C0DE);
      tick(); idle();
      dec_rs1 = 5'd16; dec_rs2 = 5'd17;
      #1; chk("final_stall", dec_stall, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
